// File: rtl/ysyx_22050854_divider_2.sv
// Sequential 64/32-bit restoring divider with a valid/ready handshake and flush.
// Divide-by-zero and signed overflow finish in one cycle without iterating.
module ysyx_22050854_divider_2 (
  input  logic        clock,
  input  logic        reset,
  input  logic [63:0] dividend,
  input  logic [63:0] divisor,
  input  logic        div_valid,
  input  logic        divw,
  input  logic        div_signed,
  input  logic        flush,
  output logic        div_doing,
  output logic        div_ready,
  output logic        out_valid,
  output logic [63:0] quotient,
  output logic [63:0] remainder
);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t      state, state_next;
  logic [63:0] rem_q, quo_q, dvs_q;
  logic [6:0]  cnt;
  logic        w_q, q_neg, r_neg;

  logic        accept, a_neg, b_neg, div_zero, overflow, special, last, ge;
  logic [63:0] a_val, b_val, a_sext, a_mag, b_mag, spec_q, spec_r;
  logic [64:0] partial;
  logic [63:0] sub, rem_step, quo_step, q_mag, r_mag, q_sgn, r_sgn, q_fin, r_fin;

  // Operand decode: word ops are widened first so the sign lands in bit 63.
  always_comb begin
    a_val    = divw ? (div_signed ? {{32{dividend[31]}}, dividend[31:0]} : {32'b0, dividend[31:0]}) : dividend;
    b_val    = divw ? (div_signed ? {{32{divisor[31]}}, divisor[31:0]} : {32'b0, divisor[31:0]}) : divisor;
    a_sext   = divw ? {{32{dividend[31]}}, dividend[31:0]} : dividend;
    a_neg    = div_signed & a_val[63];
    b_neg    = div_signed & b_val[63];
    a_mag    = a_neg ? -a_val : a_val;
    b_mag    = b_neg ? -b_val : b_val;
    div_zero = (b_val == 64'd0);
    overflow = div_signed && (b_val == '1) &&
               (a_val == (divw ? 64'hFFFF_FFFF_8000_0000 : 64'h8000_0000_0000_0000));
    special  = div_zero | overflow;
    spec_q   = div_zero ? '1 : a_sext;
    spec_r   = div_zero ? a_sext : 64'd0;
    accept   = (state == IDLE) && div_valid && !flush;
    last     = (cnt == (w_q ? 7'd31 : 7'd63));
  end

  // One restoring step; the partial remainder can exceed 64 bits only transiently.
  always_comb begin
    partial  = {rem_q, quo_q[63]};
    ge       = partial[64] | (partial[63:0] >= dvs_q);
    sub      = partial[63:0] - dvs_q;
    rem_step = ge ? sub : partial[63:0];
    quo_step = {quo_q[62:0], ge};
    q_mag    = w_q ? {32'b0, quo_step[31:0]} : quo_step;
    r_mag    = w_q ? {32'b0, rem_step[31:0]} : rem_step;
    q_sgn    = q_neg ? -q_mag : q_mag;
    r_sgn    = r_neg ? -r_mag : r_mag;
    q_fin    = w_q ? {{32{q_sgn[31]}}, q_sgn[31:0]} : q_sgn;
    r_fin    = w_q ? {{32{r_sgn[31]}}, r_sgn[31:0]} : r_sgn;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (accept) state_next = special ? DONE : CALC;
      CALC:    if (flush) state_next = IDLE;
               else if (last) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
    div_ready = (state == IDLE);
    div_doing = (state == CALC);
    out_valid = (state == DONE) && !flush;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_next;
  end

  // Results are written only when entering DONE, so they hold through CALC.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      rem_q     <= 64'd0;
      quo_q     <= 64'd0;
      dvs_q     <= 64'd0;
      cnt       <= 7'd0;
      w_q       <= 1'b0;
      q_neg     <= 1'b0;
      r_neg     <= 1'b0;
      quotient  <= 64'd0;
      remainder <= 64'd0;
    end else begin
      case (state)
        IDLE: if (accept) begin
          cnt   <= 7'd0;
          rem_q <= 64'd0;
          quo_q <= divw ? {a_mag[31:0], 32'b0} : a_mag;
          dvs_q <= b_mag;
          w_q   <= divw;
          q_neg <= a_neg ^ b_neg;
          r_neg <= a_neg;
          if (special) begin
            quotient  <= spec_q;
            remainder <= spec_r;
          end
        end
        CALC: if (!flush) begin
          rem_q <= rem_step;
          quo_q <= quo_step;
          cnt   <= cnt + 7'd1;
          if (last) begin
            quotient  <= q_fin;
            remainder <= r_fin;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_ysyx_22050854_divider_2.sv
// Randomized scoreboard bench for ysyx_22050854_divider_2: a driver pushes expected
// results from an arithmetic model, a monitor pops and compares on out_valid.
module tb_ysyx_22050854_divider_2;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic [63:0] dividend = '0, divisor = '0;
  logic        div_valid = 1'b0, divw = 1'b0, div_signed = 1'b0, flush = 1'b0;
  logic        div_doing, div_ready, out_valid;
  logic [63:0] quotient, remainder;

  ysyx_22050854_divider_2 dut (
    .clock(clock), .reset(reset), .dividend(dividend), .divisor(divisor),
    .div_valid(div_valid), .divw(divw), .div_signed(div_signed), .flush(flush),
    .div_doing(div_doing), .div_ready(div_ready), .out_valid(out_valid),
    .quotient(quotient), .remainder(remainder)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc++;

  typedef struct {
    logic [63:0] q;
    logic [63:0] r;
    int          lat;
    int          doing;
    int          acc;
  } exp_t;

  exp_t        sb[$];
  int          checks = 0;
  int          passed = 0;
  logic [63:0] last_q = '0, last_r = '0;
  logic        prev_valid = 1'b0;
  int          doing_cnt = 0;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp_v);
    checks++;
    if (act === exp_v) passed++;
    else $display("[TB] FAIL %s: got 0x%h expected 0x%h (cycle %0d)", name, act, exp_v, cyc);
  endtask

  // Plain-arithmetic model of the divider, including the two early-out cases.
  function automatic void refModel(input logic [63:0] a, input logic [63:0] b, input logic w,
                                   input logic s, output logic [63:0] q, output logic [63:0] r,
                                   output int lat, output int doing);
    logic [31:0] a32, b32, q32, r32;
    int          sa, sd;
    longint      la, lb;
    a32 = a[31:0];
    b32 = b[31:0];
    if (w) begin
      if (b32 == 32'd0) begin
        q = '1; r = {{32{a32[31]}}, a32}; lat = 1; doing = 0;
        return;
      end
      if (s && a32 == 32'h8000_0000 && b32 == 32'hFFFF_FFFF) begin
        q = {{32{a32[31]}}, a32}; r = '0; lat = 1; doing = 0;
        return;
      end
      if (s) begin
        sa = a32; sd = b32;
        q32 = sa / sd; r32 = sa % sd;
      end else begin
        q32 = a32 / b32; r32 = a32 % b32;
      end
      q = {{32{q32[31]}}, q32}; r = {{32{r32[31]}}, r32}; lat = 33; doing = 32;
    end else begin
      if (b == 64'd0) begin
        q = '1; r = a; lat = 1; doing = 0;
        return;
      end
      if (s && a == 64'h8000_0000_0000_0000 && b == '1) begin
        q = a; r = '0; lat = 1; doing = 0;
        return;
      end
      if (s) begin
        la = a; lb = b;
        q = la / lb; r = la % lb;
      end else begin
        q = a / b; r = a % b;
      end
      lat = 65; doing = 64;
    end
  endfunction

  // Waits for an idle slot, issues one request and scrambles the inputs afterwards.
  task automatic applyStimulus(input logic [63:0] a, input logic [63:0] b, input logic w,
                               input logic s, input bit push);
    exp_t e;
    int   waited = 0;
    @(negedge clock);
    while (!div_ready || !reset) begin
      if (waited++ > 300) begin
        checks++;
        $display("[TB] FAIL ready timeout: div_ready=%0b required 1", div_ready);
        return;
      end
      @(negedge clock);
    end
    dividend = a; divisor = b; divw = w; div_signed = s; div_valid = 1'b1;
    @(posedge clock);
    #1;
    div_valid  = 1'b0;
    dividend   = {$urandom, $urandom};
    divisor    = {$urandom, $urandom};
    divw       = 1'($urandom);
    div_signed = 1'($urandom);
    if (push) begin
      refModel(a, b, w, s, e.q, e.r, e.lat, e.doing);
      e.acc = cyc - 1;
      sb.push_back(e);
    end
  endtask

  always @(negedge clock) begin
    exp_t e;
    if (!reset) begin
      last_q = '0; last_r = '0; prev_valid = 1'b0; doing_cnt = 0;
    end else begin
      if (div_ready) doing_cnt = 0;
      if (div_doing) begin
        doing_cnt++;
        checkOutput("quotient held in CALC", quotient, last_q);
      end
      if (out_valid) begin
        checkOutput("out_valid single cycle", {63'b0, prev_valid}, 64'd0);
        if (sb.size() == 0) begin
          checks++;
          $display("[TB] FAIL unexpected out_valid: got 1 required 0 (cycle %0d)", cyc);
        end else begin
          e = sb.pop_front();
          checkOutput("quotient", quotient, e.q);
          checkOutput("remainder", remainder, e.r);
          checkOutput("latency", 64'(cyc - e.acc), 64'(e.lat));
          checkOutput("div_doing cycles", 64'(doing_cnt), 64'(e.doing));
          last_q = e.q; last_r = e.r;
        end
      end
      prev_valid = out_valid;
    end
  end

  initial begin
    logic [63:0] a, b;
    logic        w, s;
    int          m, waited;

    repeat (3) @(posedge clock);
    @(negedge clock);
    checkOutput("reset div_ready", {63'b0, div_ready}, 64'd1);
    checkOutput("reset div_doing", {63'b0, div_doing}, 64'd0);
    checkOutput("reset out_valid", {63'b0, out_valid}, 64'd0);
    checkOutput("reset quotient", quotient, 64'd0);
    checkOutput("reset remainder", remainder, 64'd0);
    reset = 1'b1;

    applyStimulus(-64'sd7, 64'd2, 1'b0, 1'b1, 1'b1);
    applyStimulus(64'h0000_0000_FFFF_FFFF, 64'd1, 1'b1, 1'b0, 1'b1);
    applyStimulus(64'd100, 64'd0, 1'b0, 1'b0, 1'b1);
    applyStimulus(64'h8000_0000_0000_0000, '1, 1'b0, 1'b1, 1'b1);
    applyStimulus(64'h0000_0000_8000_0000, 64'h0000_0000_FFFF_FFFF, 1'b1, 1'b1, 1'b1);

    // A flush alongside a request in IDLE must win; a zero divisor would otherwise go straight to DONE.
    @(negedge clock);
    while (!div_ready) @(negedge clock);
    dividend = 64'd5; divisor = 64'd0; divw = 1'b0; div_signed = 1'b0;
    div_valid = 1'b1; flush = 1'b1;
    @(posedge clock);
    #1;
    div_valid = 1'b0; flush = 1'b0;
    checkOutput("flush blocks accept", {63'b0, div_ready}, 64'd1);

    applyStimulus(64'd123456789, 64'd3, 1'b0, 1'b0, 1'b0);
    repeat (9) @(posedge clock);
    #1;
    checkOutput("doing before flush", {63'b0, div_doing}, 64'd1);
    flush = 1'b1;
    @(posedge clock);
    #1;
    flush = 1'b0;
    checkOutput("ready after flush", {63'b0, div_ready}, 64'd1);
    checkOutput("doing after flush", {63'b0, div_doing}, 64'd0);
    checkOutput("quotient kept by flush", quotient, last_q);
    checkOutput("remainder kept by flush", remainder, last_r);
    applyStimulus(64'd1000, 64'd7, 1'b0, 1'b0, 1'b1);

    applyStimulus({$urandom, $urandom}, 64'd3, 1'b0, 1'b1, 1'b0);
    repeat (19) @(posedge clock);
    #1;
    reset = 1'b0;
    #1;
    checkOutput("mid-CALC reset quotient", quotient, 64'd0);
    checkOutput("mid-CALC reset remainder", remainder, 64'd0);
    checkOutput("mid-CALC reset div_doing", {63'b0, div_doing}, 64'd0);
    checkOutput("mid-CALC reset out_valid", {63'b0, out_valid}, 64'd0);
    checkOutput("mid-CALC reset div_ready", {63'b0, div_ready}, 64'd1);
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b1;
    applyStimulus(64'd12, -64'sd5, 1'b0, 1'b1, 1'b1);

    for (int i = 0; i < 80; i++) begin
      w = 1'($urandom);
      s = 1'($urandom);
      a = {$urandom, $urandom};
      b = {$urandom, $urandom};
      m = $urandom_range(0, 7);
      case (m)
        0: b = '0;
        1: begin
          b = '1;
          if ($urandom_range(0, 1) == 1) a = w ? 64'h0000_0000_8000_0000 : 64'h8000_0000_0000_0000;
        end
        2: b = 64'($urandom_range(1, 15)) * (($urandom_range(0, 1) == 1) ? 64'd1 : '1);
        3: b = b >> $urandom_range(0, 62);
        default: ;
      endcase
      applyStimulus(a, b, w, s, 1'b1);
    end

    waited = 0;
    while (sb.size() != 0 && waited < 200) begin
      @(negedge clock);
      waited++;
    end
    if (sb.size() != 0) begin
      checks++;
      $display("[TB] FAIL drain timeout: %0d results outstanding, required 0", sb.size());
    end

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/ysyx_22050854_divider_2.md
YSYX_22050854_DIVIDER_2 -- requirements
Module: ysyx_22050854_divider_2

Interface
REQ-001 The block SHALL have no parameters; the data width is fixed at 64 bits.
REQ-002 clock  input  1  single clock; all state updates on the rising edge.
REQ-003 reset  input  1  asynchronous, active-low reset (0 = reset asserted).
REQ-004 dividend  input  64  numerator, sampled only on accept.
REQ-005 divisor  input  64  denominator, sampled only on accept.
REQ-006 div_valid  input  1  request; accept happens when div_valid=1 and div_ready=1.
REQ-007 divw  input  1  1 = 32-bit operation on bits [31:0].
REQ-008 div_signed  input  1  1 = two's-complement operands.
REQ-009 flush  input  1  1 = abort the current operation.
REQ-010 div_doing  output  1  high while iterating.
REQ-011 div_ready  output  1  high when idle and able to accept.
REQ-012 out_valid  output  1  one-cycle pulse marking the results valid.
REQ-013 quotient  output  64  result quotient.
REQ-014 remainder  output  64  result remainder.

Function
REQ-015 FSM SHALL have states IDLE, CALC and DONE.
- div_ready=1 only in IDLE.
- div_doing=1 only in CALC.
- out_valid=1 only in DONE.
REQ-016 IDLE->CALC SHALL occur on an accepted request; div_valid with div_ready=0 is ignored.
REQ-017 Iterations SHALL be restoring shift-subtract, one quotient bit per cycle, on operand magnitudes: N=64 iterations, or N=32 when divw=1.
REQ-018 Normal-case timing: accept at cycle 0, CALC during cycles 1..N, DONE (out_valid=1) in cycle N+1, then IDLE in cycle N+2.
REQ-019 Signed mode: magnitudes SHALL be used; the quotient is negated if the operand signs differ; the remainder takes the sign of the dividend.
REQ-020 Unsigned mode SHALL treat the operands as unsigned.
REQ-021 divw=1: only bits [31:0] of the operands are used (sign taken from bit 31 when signed); quotient[31:0] and remainder[31:0] SHALL each be sign-extended from bit 31 to 64 bits, for both signed and unsigned.
REQ-022 Divisor zero (at the active width): quotient = all ones, remainder = dividend (sign-extended when divw); accept->DONE directly, out_valid in cycle 1.
REQ-023 Signed overflow (most-negative / -1 at the active width): quotient = dividend (sign-extended when divw), remainder = 0; accept->DONE directly, out_valid in cycle 1.
REQ-024 quotient and remainder SHALL hold their last values from DONE until the next DONE; they do not change during CALC.
REQ-025 Input changes after accept SHALL NOT affect the result.
REQ-026 flush=1 in CALC or DONE SHALL force IDLE at the next edge and suppress out_valid; quotient and remainder are left unchanged.
REQ-027 flush=1 together with div_valid=1 in IDLE SHALL block the accept; flush has priority.
REQ-028 out_valid SHALL never last more than one cycle, so a requester gating issue with !out_valid does not see a stale completion.
REQ-029 A new request SHALL be acceptable in the cycle after DONE.

Reset
REQ-030 While reset=0, the block SHALL immediately (asynchronously) enter IDLE with div_doing=0, out_valid=0, quotient=0, remainder=0 and the iteration counter cleared.
REQ-031 div_ready SHALL read 1 once in IDLE, including during reset.
REQ-032 Reset asserted mid-CALC SHALL abandon the operation with no out_valid afterwards.

Verification
REQ-033 64-bit signed -7 / 2 -> quotient=0xFFFFFFFFFFFFFFFD, remainder=0xFFFFFFFFFFFFFFFF; div_doing high for exactly 64 cycles; out_valid in cycle 65 for exactly 1 cycle.
REQ-034 divw unsigned 0x00000000FFFFFFFF / 1 -> quotient=0xFFFFFFFFFFFFFFFF, remainder=0; out_valid in cycle 33.
REQ-035 64-bit unsigned 100 / 0 -> quotient=0xFFFFFFFFFFFFFFFF, remainder=100; out_valid in cycle 1; div_doing never high.
REQ-036 Signed overflow:
- 64-bit 0x8000000000000000 / 0xFFFFFFFFFFFFFFFF -> quotient=0x8000000000000000, remainder=0.
- divw 0x80000000 / 0xFFFFFFFF -> quotient=0xFFFFFFFF80000000, remainder=0.
- Both complete with out_valid in cycle 1.
REQ-037 flush=1 in cycle 10 of a 64-bit operation -> IDLE and div_ready=1 in cycle 11, no out_valid; a following 1000 / 7 unsigned -> quotient=142, remainder=6.
REQ-038 reset=0 in cycle 20 of CALC -> outputs cleared immediately (quotient=0, remainder=0, div_doing=0, out_valid=0); after release, 12 / -5 signed -> quotient=0xFFFFFFFFFFFFFFFE, remainder=2.
